// File: rtl/riscv_irq_ctrl.sv
// riscv_irq_ctrl -- multi-source interrupt controller for a RISC-V core.
//
// Synchronises NUM_IRQ asynchronous interrupt lines, latches each as an
// edge- or level-triggered source, resolves fixed priority (lowest index
// wins) and presents a single request with id and vector to the core.
// One interrupt is tracked in service through an ack / EOI handshake;
// there is no nesting.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   irq_i        raw asynchronous interrupt lines
//   cfg_we_i     config write strobe
//   cfg_addr_i   0 ENABLE, 1 EDGE, 2 PENDING (W1C), 3 STATUS (read-only)
//   cfg_wdata_i  config write data, bits [NUM_IRQ-1:0] used
//   cfg_rdata_o  config read data, combinational on cfg_addr_i
//   irq_req_o    request to core
//   irq_id_o     winning source id
//   irq_vec_o    VEC_BASE + irq_id_o*VEC_STRIDE
//   irq_ack_i    core takes the trap (only honoured while irq_req_o=1)
//   irq_eoi_i    core returns from handler (only honoured in service)
module riscv_irq_ctrl #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned BITNESS     = 32,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [BITNESS-1:0] cfg_wdata_i,
  output logic [BITNESS-1:0] cfg_rdata_o,
  output logic               irq_req_o,
  output logic [IDW-1:0]     irq_id_o,
  output logic [BITNESS-1:0] irq_vec_o,
  input  logic               irq_ack_i,
  input  logic               irq_eoi_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  function automatic logic [BITNESS-1:0] vec_of(input logic [IDW-1:0] id);
    return BITNESS'(VEC_BASE) + BITNESS'(id) * BITNESS'(VEC_STRIDE);
  endfunction

  logic [NUM_IRQ-1:0] sync_ff [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_q, sync_prev, rise;
  logic [NUM_IRQ-1:0] enable, edge_mode, pend_edge, pend_edge_d;
  logic [NUM_IRQ-1:0] pending, eligible, w1c, ack_clr;
  logic [IDW-1:0]     winner, id_q;
  logic [BITNESS-1:0] vec_q;
  logic               any_eligible, latch_id;
  state_t             state_q, state_d;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata_i;

  // Synchroniser chain; sync_prev provides the edge-detect history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
      sync_prev <= '0;
    end else begin
      sync_ff[0] <= irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
      sync_prev <= sync_q;
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];
  assign rise   = sync_q & ~sync_prev;

  assign w1c = (cfg_we_i && cfg_addr_i == 2'd2) ? cfg_wdata_i[NUM_IRQ-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    if (state_q == S_REQ && irq_ack_i) ack_clr[id_q] = 1'b1;
  end

  // A new rising edge wins over a same-cycle clear. Only edge sources keep
  // state here; level sources are taken straight from the synchroniser.
  assign pend_edge_d = (rise | (pend_edge & ~(w1c | ack_clr))) & edge_mode;
  assign pending     = (pend_edge & edge_mode) | (sync_q & ~edge_mode);
  assign eligible    = pending & enable;
  assign any_eligible = |eligible;

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDW'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable    <= '0;
      edge_mode <= '0;
      pend_edge <= '0;
    end else begin
      if (cfg_we_i && cfg_addr_i == 2'd0) enable    <= cfg_wdata_i[NUM_IRQ-1:0];
      if (cfg_we_i && cfg_addr_i == 2'd1) edge_mode <= cfg_wdata_i[NUM_IRQ-1:0];
      pend_edge <= pend_edge_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_id = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_eligible) begin
          state_d  = S_REQ;
          latch_id = 1'b1;
        end
      end
      S_REQ: begin
        // No preemption: only the latched source can keep the request alive.
        if (irq_ack_i)          state_d = S_SERVICE;
        else if (!eligible[id_q]) state_d = S_IDLE;
      end
      S_SERVICE: begin
        if (irq_eoi_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      vec_q   <= BITNESS'(VEC_BASE);
    end else begin
      state_q <= state_d;
      if (latch_id) begin
        id_q  <= winner;
        vec_q <= vec_of(winner);
      end
    end
  end

  assign irq_req_o = (state_q == S_REQ);
  assign irq_id_o  = id_q;
  assign irq_vec_o = vec_q;

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      2'd0: cfg_rdata_o[NUM_IRQ-1:0] = enable;
      2'd1: cfg_rdata_o[NUM_IRQ-1:0] = edge_mode;
      2'd2: cfg_rdata_o[NUM_IRQ-1:0] = pending;
      default: begin
        cfg_rdata_o[0]        = (state_q == S_REQ);
        cfg_rdata_o[1]        = (state_q == S_SERVICE);
        cfg_rdata_o[8 +: IDW] = id_q;
      end
    endcase
  end

endmodule
